specs_alarm_collector: RTL and testbench

Receiving end of the SPECS checker vector. Takes the 32-bit checkersFired word from the assertion block each cycle and rising-edge detects each checker bit. It records which checkers fired, with timestamp and EX-stage PC, into a small event FIFO that the debug unit/host drains over a valid/ready port. It also maintains sticky status and an interrupt request for the recovery logic.

---
 rtl/specs_alarm_pkg.sv | 29 ++
 rtl/specs_alarm_fifo.sv | 46 ++++
 rtl/specs_alarm_collector.sv | 93 +++++++++
 tb/tb_specs_alarm_collector.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/specs_alarm_pkg.sv
// rtl/specs_alarm_pkg.sv - shared event type, checker indices and edge helper for the SPECS alarm collector
package specs_alarm_pkg;

  localparam int EVT_TS_W = 16;

  localparam int CHK_1  = 1;
  localparam int CHK_3  = 3;
  localparam int CHK_5  = 5;
  localparam int CHK_8  = 8;
  localparam int CHK_9  = 9;
  localparam int CHK_13 = 13;
  localparam int CHK_15 = 15;
  localparam int CHK_16 = 16;
  localparam int CHK_18 = 18;
  localparam int CHK_19 = 19;

  typedef struct packed {
    logic [31:0]         bits;
    logic [31:0]         pc;
    logic [EVT_TS_W-1:0] ts;
  } evt_t;

  function automatic logic [31:0] rising_edges(input logic [31:0] cur,
                                               input logic [31:0] prv,
                                               input logic [31:0] msk);
    return cur & ~prv & msk;
  endfunction

endpackage

// File: rtl/specs_alarm_fifo.sv
// rtl/specs_alarm_fifo.sv - first-word-fall-through synchronous FIFO
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module specs_alarm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/specs_alarm_collector.sv
// rtl/specs_alarm_collector.sv - rising-edge collector for the SPECS checker vector
// Queues timestamped events, keeps sticky status, drop/event counters and an irq.
module specs_alarm_collector
  import specs_alarm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = EVT_TS_W,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      checkers_fired,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      mask,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [31:0]      evt_bits,
  output logic [31:0]      evt_pc,
  output logic [TS_W-1:0]  evt_ts,
  output logic [31:0]      sticky,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             irq
);

  localparam int              EW      = 64 + TS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts;
  logic [31:0]      prev;
  logic [31:0]      new_bits;
  logic             push_req;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] drop_base;
  logic [CNT_W-1:0] evt_base;

  assign new_bits = enable ? rising_edges(checkers_fired, prev, mask) : 32'd0;
  assign push_req = |new_bits;
  assign pop      = evt_valid & evt_ready;
  // A full FIFO still takes the new event when the head leaves in the same cycle.
  assign accept   = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  assign evt_valid = ~fifo_empty;
  assign {evt_bits, evt_pc, evt_ts} = evt_valid ? head : {EW{1'b0}};

  assign drop_base = clr ? {CNT_W{1'b0}} : drop_cnt;
  assign evt_base  = clr ? {CNT_W{1'b0}} : evt_cnt;

  specs_alarm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({new_bits, ex_pc, ts}),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts       <= '0;
      prev     <= '0;
      sticky   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      evt_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (enable) prev <= checkers_fired;
      sticky   <= (clr ? 32'd0 : sticky) | new_bits;
      // A drop in the clear cycle wins over the clear.
      overflow <= drop | (overflow & ~clr);
      drop_cnt <= (drop && drop_base != CNT_MAX) ? drop_base + 1'b1 : drop_base;
      evt_cnt  <= (accept && evt_base != CNT_MAX) ? evt_base + 1'b1 : evt_base;
      irq      <= (|sticky) | overflow;
    end
  end

endmodule

// File: tb/tb_specs_alarm_collector.sv
// tb/tb_specs_alarm_collector.sv - randomized and directed bench for specs_alarm_collector
module tb_specs_alarm_collector;
  import specs_alarm_pkg::*;

  localparam int DEPTH = 4;
  localparam int TSW   = 16;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [31:0]     cf;
  logic [31:0]     ex_pc;
  logic [31:0]     mask;
  logic            clr;
  logic            evt_valid;
  logic            evt_ready;
  logic [31:0]     evt_bits;
  logic [31:0]     evt_pc;
  logic [TSW-1:0]  evt_ts;
  logic [31:0]     sticky;
  logic            overflow;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   evt_cnt;
  logic            irq;
  logic [130:0]    dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  specs_alarm_collector #(.FIFO_DEPTH(DEPTH), .TS_W(TSW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .checkers_fired(cf), .ex_pc(ex_pc),
    .mask(mask), .clr(clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_bits(evt_bits), .evt_pc(evt_pc), .evt_ts(evt_ts), .sticky(sticky),
    .overflow(overflow), .drop_cnt(drop_cnt), .evt_cnt(evt_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  assign dut_vec = {evt_valid, evt_bits, evt_pc, evt_ts, sticky, overflow, drop_cnt, evt_cnt, irq};

  // Reference model: event queue plus counters, stepped once per clock from the inputs.
  evt_t        mq[$];
  logic [31:0] m_prev, m_sticky;
  logic        m_ovf, m_irq;
  int          m_drop, m_evt, m_ts;

  task automatic model_step();
    logic [31:0] nb;
    logic        irq_n;
    bit          acc, drp;
    evt_t        e;
    if (!rst) begin
      mq.delete();
      m_prev = 0; m_sticky = 0; m_ovf = 0; m_irq = 0;
      m_drop = 0; m_evt = 0; m_ts = 0;
      return;
    end
    irq_n = (m_sticky != 0) || m_ovf;
    nb = 0;
    if (enable) begin
      nb = cf & ~m_prev & mask;
      m_prev = cf;
    end
    if (evt_ready && mq.size() > 0) void'(mq.pop_front());
    acc = 0; drp = 0;
    if (nb != 0) begin
      if (mq.size() < DEPTH) begin
        e.bits = nb; e.pc = ex_pc; e.ts = 16'(m_ts);
        mq.push_back(e);
        acc = 1;
      end else drp = 1;
    end
    if (clr) begin
      m_sticky = 0; m_ovf = 0; m_drop = 0; m_evt = 0;
    end
    m_sticky |= nb;
    if (drp) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    if (acc && m_evt < 255) m_evt++;
    m_ts = (m_ts + 1) % 65536;
    m_irq = irq_n;
  endtask

  function automatic logic [130:0] model_vec();
    evt_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    return {mq.size() > 0, h.bits, h.pc, h.ts, m_sticky, m_ovf, 8'(m_drop), 8'(m_evt), m_irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; cf = '0; ex_pc = '0; mask = '0; clr = 1'b0; evt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", dut_vec, model_vec());
    end
    n_tests++;
    if (dut_vec !== 131'd0) begin
      n_fail++; $display("FAIL reset_zero: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_single_edge();
    do_reset();
    enable = 1; mask = '1; ex_pc = 32'h2000; cf = 32'h8;
    tick();
    n_tests++;
    if ({evt_valid, evt_bits, evt_pc, sticky, evt_cnt, irq} !== {1'b1, 32'h8, 32'h2000, 32'h8, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL single_first: got v=%b b=%h pc=%h st=%h cnt=%0d irq=%b want 1 8 2000 8 1 0",
                         evt_valid, evt_bits, evt_pc, sticky, evt_cnt, irq);
    end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL single_irq: got %b want 1", irq);
    end
    tick();
    n_tests++;
    if (dut_vec !== model_vec() || evt_cnt !== 8'd1) begin
      n_fail++; $display("FAIL single_held: got %h want %h", dut_vec, model_vec());
    end
    cf = 0; evt_ready = 1;
    tick();
    evt_ready = 0;
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_only_one: got valid %b want 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1; mask = '1; evt_ready = 0;
    for (int i = 0; i < 6; i++) begin
      cf = 32'h2; ex_pc = $urandom;
      tick();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL overflow_edge%0d: got %h want %h", i, dut_vec, model_vec());
      end
      cf = 0;
      tick();
    end
    n_tests++;
    if ({overflow, drop_cnt, sticky, evt_cnt} !== {1'b1, 8'd2, 32'h2, 8'd4}) begin
      n_fail++; $display("FAIL overflow_state: got ovf=%b drop=%0d st=%h cnt=%0d want 1 2 2 4",
                         overflow, drop_cnt, sticky, evt_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    int          cnt, last_ts;
    bit          ordered;
    logic [31:0] last_bits;
    evt_ready = 1; cf = 32'h1 << CHK_19; ex_pc = 32'h3000;
    tick();
    n_tests++;
    if (dut_vec !== model_vec() || drop_cnt !== 8'd2 || evt_cnt !== 8'd5) begin
      n_fail++; $display("FAIL fullpp_cycle: got %h want %h", dut_vec, model_vec());
    end
    cf = 0; cnt = 0; last_ts = -1; ordered = 1; last_bits = 0;
    for (int k = 0; k < 10 && evt_valid; k++) begin
      if (int'(evt_ts) <= last_ts) ordered = 0;
      last_ts = int'(evt_ts);
      last_bits = evt_bits;
      cnt++;
      tick();
    end
    evt_ready = 0;
    n_tests++;
    if (cnt !== 4 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL fullpp_occupancy: got %0d entries (valid %b) want 4", cnt, evt_valid);
    end
    n_tests++;
    if (!ordered || last_bits !== 32'h0008_0000) begin
      n_fail++; $display("FAIL fullpp_order: ordered=%0d last_bits=%h want 1 00080000", ordered, last_bits);
    end
  endtask

  task automatic test_mask();
    do_reset();
    enable = 1; mask = 32'hFFFF_FFF7; cf = 0;
    tick();
    cf = 32'hA;
    tick();
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL mask_model: got %h want %h", dut_vec, model_vec());
    end
    n_tests++;
    if (evt_bits !== 32'h2 || sticky !== 32'h2) begin
      n_fail++; $display("FAIL mask_bits: got bits=%h sticky=%h want 2 2", evt_bits, sticky);
    end
  endtask

  task automatic test_enable_gate();
    do_reset();
    enable = 0; mask = '1; cf = 0;
    tick();
    cf = 32'h10;
    tick();
    tick();
    n_tests++;
    if (evt_valid !== 1'b0 || sticky !== 32'h0) begin
      n_fail++; $display("FAIL gate_disabled: got valid=%b sticky=%h want 0 0", evt_valid, sticky);
    end
    enable = 1;
    tick();
    n_tests++;
    if ({evt_valid, evt_bits, evt_cnt} !== {1'b1, 32'h10, 8'd1}) begin
      n_fail++; $display("FAIL gate_first_enabled: got v=%b b=%h cnt=%0d want 1 10 1", evt_valid, evt_bits, evt_cnt);
    end
    tick();
    n_tests++;
    if (dut_vec !== model_vec() || evt_cnt !== 8'd1) begin
      n_fail++; $display("FAIL gate_held: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_clr_and_reset();
    do_reset();
    enable = 1; mask = '1; evt_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cf = 32'h8; tick();
      cf = 0;     tick();
    end
    n_tests++;
    if ({overflow, sticky, drop_cnt} !== {1'b1, 32'h8, 8'd1}) begin
      n_fail++; $display("FAIL clr_setup: got ovf=%b st=%h drop=%0d want 1 8 1", overflow, sticky, drop_cnt);
    end
    clr = 1; cf = 32'h8;
    tick();
    clr = 0; cf = 0;
    n_tests++;
    if ({overflow, drop_cnt, sticky} !== {1'b1, 8'd1, 32'h8} || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL clr_with_drop: got ovf=%b drop=%0d st=%h want 1 1 8", overflow, drop_cnt, sticky);
    end
    tick();
    clr = 1; cf = 32'h4; evt_ready = 1;
    tick();
    clr = 0; cf = 0; evt_ready = 0;
    n_tests++;
    if ({sticky, overflow, drop_cnt, evt_cnt, evt_valid} !== {32'h4, 1'b0, 8'd0, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL clr_with_push: got st=%h ovf=%b drop=%0d cnt=%0d v=%b want 4 0 0 1 1",
                         sticky, overflow, drop_cnt, evt_cnt, evt_valid);
    end
    evt_ready = 1;
    tick();
    n_tests++;
    if (dut_vec !== model_vec() || evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL clr_drain: got %h want %h", dut_vec, model_vec());
    end
    rst = 0;
    tick();
    rst = 1; evt_ready = 0;
    n_tests++;
    if (dut_vec !== 131'd0) begin
      n_fail++; $display("FAIL reset_mid_drain: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1; mask = '1; evt_ready = 1;
    for (int i = 0; i < 270; i++) begin
      cf = 32'h1 << CHK_13; tick();
      cf = 0;               tick();
    end
    evt_ready = 0;
    for (int i = 0; i < 270; i++) begin
      cf = 32'h1 << CHK_5; tick();
      cf = 0;              tick();
    end
    n_tests++;
    if ({evt_cnt, drop_cnt} !== {8'hFF, 8'hFF} || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL saturation: got cnt=%0d drop=%0d want 255 255", evt_cnt, drop_cnt);
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    mask = '1;
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) != 0) cf = cf ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) cf = 0;
      if ($urandom_range(0, 49) == 0) mask = $urandom | (32'h1 << CHK_1) | (32'h1 << CHK_9);
      ex_pc     = $urandom;
      clr       = ($urandom_range(0, 39) == 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      tick();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        if (errs < 5) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, model_vec());
        errs++;
      end
    end
    rst = 1; clr = 0; evt_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_overflow();
    test_full_push_pop();
    test_mask();
    test_enable_gate();
    test_clr_and_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
